// File: rtl/vect_fifo_dist.sv
// vect_fifo_dist: steers whole vectors round-robin into NUM_PIPES FWFT FIFOs.
// Each stored entry carries an end-of-vector tag next to the data word.
// Optional build macro: VFD_ALMOST_FULL_EN. When it is defined, fifo_full
// asserts with two entries of headroom. Words are dropped only when a FIFO is
// truly at capacity.
module vect_fifo_dist #(
    parameter int NUM_PIPES = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fifo_we,
    input  logic [DATA_W-1:0]           write_data,
    input  logic [15:0]                 vect_size,
    output logic [NUM_PIPES-1:0]        fifo_full,
    output logic [NUM_PIPES*DATA_W-1:0] pipe_data,
    output logic [NUM_PIPES-1:0]        pipe_last,
    output logic [NUM_PIPES-1:0]        pipe_valid,
    input  logic [NUM_PIPES-1:0]        pipe_ready,
    output logic                        overflow
);

    localparam int SEL_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam logic [ADDR_W:0] CAP_CNT = (ADDR_W+1)'(DEPTH);
`ifdef VFD_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH - 2);
`else
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
`endif

    logic [SEL_W-1:0]     sel;
    logic [15:0]          word_cnt;
    logic                 is_last;
    logic [NUM_PIPES-1:0] at_cap;

    // End-of-vector detection; a zero vector size behaves as a size of one.
    always_comb begin
        is_last = (vect_size == '0) || (word_cnt == vect_size - 16'd1);
    end

    // Routing state: position within the vector, target pipe and sticky drop flag.
    // sel and word_cnt advance even on a dropped word to keep vectors aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else if (fifo_we) begin
            if (at_cap[sel]) begin
                overflow <= 1'b1;
            end
            if (is_last) begin
                word_cnt <= '0;
                sel      <= (sel == SEL_W'(NUM_PIPES - 1)) ? '0 : sel + 1'b1;
            end else begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        logic [DATA_W:0]   mem [DEPTH];
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] rd_ptr;
        logic [ADDR_W:0]   count;
        logic              push;
        logic              pop;

        // Push only into the selected pipe below capacity; pop on a valid handshake.
        always_comb begin
            push = fifo_we && (sel == SEL_W'(p)) && (count != CAP_CNT);
            pop  = (count != '0) && pipe_ready[p];
        end

        // Pointer and occupancy bookkeeping; simultaneous push and pop holds count.
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Storage write of the tagged word; contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= {is_last, write_data};
            end
        end

        assign at_cap[p]                      = (count == CAP_CNT);
        assign fifo_full[p]                   = (count >= FULL_CNT);
        assign pipe_valid[p]                  = (count != '0);
        assign pipe_data[p*DATA_W +: DATA_W]  = mem[rd_ptr][DATA_W-1:0];
        assign pipe_last[p]                   = (count != '0) && mem[rd_ptr][DATA_W];
    end

endmodule

// File: tb/tb_vect_fifo_dist.sv
// Testbench for vect_fifo_dist: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vect_fifo_dist;

    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
`ifdef VFD_ALMOST_FULL_EN
    localparam int FULL_AT = DEPTH - 2;
`else
    localparam int FULL_AT = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_we = 1'b0;
    logic [DW-1:0]    write_data = '0;
    logic [15:0]      vect_size = '0;
    logic [NP-1:0]    fifo_full;
    logic [NP*DW-1:0] pipe_data;
    logic [NP-1:0]    pipe_last;
    logic [NP-1:0]    pipe_valid;
    logic [NP-1:0]    pipe_ready = '0;
    logic             overflow;

    vect_fifo_dist #(.NUM_PIPES(NP), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .fifo_we(fifo_we), .write_data(write_data),
        .vect_size(vect_size), .fifo_full(fifo_full), .pipe_data(pipe_data),
        .pipe_last(pipe_last), .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: one queue of {last, data} per pipe plus vector position.
    logic [DW:0] mq [NP][$];
    int          m_sel;
    int          m_widx;
    bit          m_ovf;

    typedef struct {
        bit          we;
        logic [31:0] data;
        logic [15:0] vs;
        logic [1:0]  rdy;
        logic [1:0]  ev;
        logic [1:0]  ef;
        bit          eo;
        logic [31:0] d0;
        bit          l0;
        logic [31:0] d1;
        bit          l1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_sel  = 0;
        m_widx = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        fifo_we    = 1'b0;
        pipe_ready = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; the model advances from the pre-edge state.
    task automatic cyc(input bit we, input logic [DW-1:0] d, input logic [15:0] vs,
                       input logic [NP-1:0] rdy);
        bit acc;
        bit last;
        int vsi;
        fifo_we    = we;
        write_data = d;
        vect_size  = vs;
        pipe_ready = rdy;
        vsi  = int'(vs);
        acc  = (mq[m_sel].size() < DEPTH);
        last = (vsi == 0) || (m_widx == vsi - 1);
        for (int p = 0; p < NP; p++)
            if (rdy[p] && mq[p].size() > 0) void'(mq[p].pop_front());
        if (we) begin
            if (acc) mq[m_sel].push_back({last, d});
            else     m_ovf = 1'b1;
            if (last) begin
                m_widx = 0;
                m_sel  = (m_sel + 1) % NP;
            end else begin
                m_widx++;
            end
        end
        @(posedge clk);
        #1;
        fifo_we    = 1'b0;
        pipe_ready = '0;
    endtask

    task automatic check_model(input string tag);
        logic [NP-1:0] ev;
        logic [NP-1:0] ef;
        for (int p = 0; p < NP; p++) begin
            ev[p] = (mq[p].size() != 0);
            ef[p] = (mq[p].size() >= FULL_AT);
        end
        chk($sformatf("%s valid", tag), 64'(pipe_valid), 64'(ev));
        chk($sformatf("%s full", tag), 64'(fifo_full), 64'(ef));
        chk($sformatf("%s overflow", tag), 64'(overflow), 64'(m_ovf));
        for (int p = 0; p < NP; p++) begin
            if (ev[p]) begin
                chk($sformatf("%s data%0d", tag, p), 64'(pipe_data[p*DW +: DW]), 64'(mq[p][0][DW-1:0]));
                chk($sformatf("%s last%0d", tag, p), 64'(pipe_last[p]), 64'(mq[p][0][DW]));
            end
        end
    endtask

    initial begin
        do_reset();
        chk("reset valid", 64'(pipe_valid), 64'(0));
        chk("reset full", 64'(fifo_full), 64'(0));
        chk("reset overflow", 64'(overflow), 64'(0));
        chk("reset last", 64'(pipe_last), 64'(0));

        // Table: vect_size=3, six writes, then drain both pipes.
        tbl[0] = '{1'b1, 32'd0, 16'd3, 2'b00, 2'b01, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        tbl[1] = '{1'b1, 32'd1, 16'd3, 2'b00, 2'b01, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        tbl[2] = '{1'b1, 32'd2, 16'd3, 2'b00, 2'b01, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        tbl[3] = '{1'b1, 32'd3, 16'd3, 2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 1'b0, 32'd3, 1'b0};
        tbl[4] = '{1'b1, 32'd4, 16'd3, 2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 1'b0, 32'd3, 1'b0};
        tbl[5] = '{1'b1, 32'd5, 16'd3, 2'b00, 2'b11, 2'b00, 1'b0, 32'd0, 1'b0, 32'd3, 1'b0};
        tbl[6] = '{1'b0, 32'd0, 16'd3, 2'b11, 2'b11, 2'b00, 1'b0, 32'd1, 1'b0, 32'd4, 1'b0};
        tbl[7] = '{1'b0, 32'd0, 16'd3, 2'b11, 2'b11, 2'b00, 1'b0, 32'd2, 1'b1, 32'd5, 1'b1};
        tbl[8] = '{1'b0, 32'd0, 16'd3, 2'b01, 2'b10, 2'b00, 1'b0, 32'd0, 1'b0, 32'd5, 1'b1};
        tbl[9] = '{1'b0, 32'd0, 16'd3, 2'b10, 2'b00, 2'b00, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].we, tbl[i].data, tbl[i].vs, tbl[i].rdy);
            chk($sformatf("tbl%0d valid", i), 64'(pipe_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d full", i), 64'(fifo_full), 64'(tbl[i].ef));
            chk($sformatf("tbl%0d overflow", i), 64'(overflow), 64'(tbl[i].eo));
            if (tbl[i].ev[0]) begin
                chk($sformatf("tbl%0d data0", i), 64'(pipe_data[DW-1:0]), 64'(tbl[i].d0));
                chk($sformatf("tbl%0d last0", i), 64'(pipe_last[0]), 64'(tbl[i].l0));
            end
            if (tbl[i].ev[1]) begin
                chk($sformatf("tbl%0d data1", i), 64'(pipe_data[2*DW-1:DW]), 64'(tbl[i].d1));
                chk($sformatf("tbl%0d last1", i), 64'(pipe_last[1]), 64'(tbl[i].l1));
            end
        end

        // Overflow: 20-word vector into a 16-deep pipe with no consumer.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DW'(100 + i), 16'd20, 2'b00);
            if (i == 15) begin
                chk("ovf full16", 64'(fifo_full), 64'(2'b01));
                chk("ovf ovf16", 64'(overflow), 64'(0));
            end
        end
        chk("ovf full20", 64'(fifo_full), 64'(2'b01));
        chk("ovf ovf20", 64'(overflow), 64'(1));
        cyc(1'b1, 32'hBEEF, 16'd20, 2'b00);
        chk("ovf valid21", 64'(pipe_valid), 64'(2'b11));
        chk("ovf data1", 64'(pipe_data[2*DW-1:DW]), 64'(32'hBEEF));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf drain%0d", i), 64'(pipe_data[DW-1:0]), 64'(100 + i));
            cyc(1'b0, '0, 16'd20, 2'b01);
        end
        chk("ovf drained", 64'(pipe_valid), 64'(2'b10));

        // Reset mid-vector, with overflow still set from the previous sequence.
        cyc(1'b1, 32'h1, 16'd4, 2'b00);
        do_reset();
        chk("rst valid", 64'(pipe_valid), 64'(0));
        chk("rst overflow", 64'(overflow), 64'(0));
        cyc(1'b1, 32'h77, 16'd4, 2'b00);
        chk("rst pipe0 valid", 64'(pipe_valid), 64'(2'b01));
        chk("rst pipe0 data", 64'(pipe_data[DW-1:0]), 64'(32'h77));
        chk("rst pipe0 last", 64'(pipe_last[0]), 64'(0));
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h78 + i), 16'd4, 2'b00);
        chk("rst vec0 valid", 64'(pipe_valid), 64'(2'b01));
        cyc(1'b1, 32'h80, 16'd4, 2'b00);
        chk("rst vec1 valid", 64'(pipe_valid), 64'(2'b11));
        chk("rst vec1 data", 64'(pipe_data[2*DW-1:DW]), 64'(32'h80));

        // Same-cycle push and pop on a single-entry pipe.
        do_reset();
        cyc(1'b1, 32'h11, 16'd4, 2'b00);
        chk("pp head", 64'(pipe_data[DW-1:0]), 64'(32'h11));
        cyc(1'b1, 32'hA5, 16'd4, 2'b01);
        chk("pp valid", 64'(pipe_valid), 64'(2'b01));
        chk("pp data", 64'(pipe_data[DW-1:0]), 64'(32'hA5));
        cyc(1'b0, '0, 16'd4, 2'b01);
        chk("pp count1", 64'(pipe_valid), 64'(2'b00));

        // Zero vector size: every word is a one-word vector.
        do_reset();
        cyc(1'b1, 32'hA, 16'd0, 2'b00);
        cyc(1'b1, 32'hB, 16'd0, 2'b00);
        cyc(1'b1, 32'hC, 16'd0, 2'b00);
        chk("vs0 valid", 64'(pipe_valid), 64'(2'b11));
        chk("vs0 d0", 64'(pipe_data[DW-1:0]), 64'(32'hA));
        chk("vs0 d1", 64'(pipe_data[2*DW-1:DW]), 64'(32'hB));
        chk("vs0 last", 64'(pipe_last), 64'(2'b11));
        cyc(1'b0, '0, 16'd0, 2'b01);
        chk("vs0 d0 second", 64'(pipe_data[DW-1:0]), 64'(32'hC));
        chk("vs0 l0 second", 64'(pipe_last[0]), 64'(1));

`ifdef VFD_ALMOST_FULL_EN
        // Almost-full threshold with headroom writes still accepted.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, DW'(i), 16'd20, 2'b00);
            if (i == 12) chk("af full13", 64'(fifo_full), 64'(0));
        end
        chk("af full14", 64'(fifo_full), 64'(2'b01));
        cyc(1'b1, 32'd14, 16'd20, 2'b00);
        cyc(1'b1, 32'd15, 16'd20, 2'b00);
        chk("af overflow16", 64'(overflow), 64'(0));
        check_model("af");
        cyc(1'b1, 32'd16, 16'd20, 2'b00);
        chk("af overflow17", 64'(overflow), 64'(1));
`endif

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 6; seg++) begin
            logic [15:0] vs;
            do_reset();
            vs = (seg == 5) ? 16'd20 : 16'($urandom_range(0, 6));
            for (int n = 0; n < 300; n++) begin
                bit            we;
                logic [NP-1:0] rdy;
                we  = ($urandom_range(0, 3) != 0);
                rdy = (seg % 2 == 1) ? NP'($urandom_range(0, 3) & $urandom_range(0, 3))
                                     : NP'($urandom_range(0, 3));
                if ($urandom_range(0, 199) == 0) do_reset();
                cyc(we, DW'($urandom), vs, rdy);
                check_model($sformatf("rnd s%0d n%0d", seg, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
